reg_file_param: RTL and testbench

//  - Parametrised general-purpose register file for the processor datapath: DATA_W x DEPTH entries.
//  - Two combinational read ports and one synchronous write port.
//  - Optional hardwired zero register and optional write-to-read bypass.
//  - Built-in bulk-clear sequencer, so a soft clear does not need a global reset.

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_param_entry.sv | 22 ++
 rtl/reg_file_param.sv | 102 ++++++++++
 tb/tb_reg_file_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and clear-FSM encoding for the register file
package reg_file_pkg;

  // Clear sequencer state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Default geometry
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/reg_file_param_entry.sv
// rtl/reg_file_param_entry.sv - single register file entry with sync clear and write enable
module reg_entry #(
  parameter int DATA_W = reg_file_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear has priority over write so the sequencer always leaves a zero behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R1W register file with bypass, zero register and bulk clear
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrIndex,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] rd0Index,
  input  logic [ADDR_W-1:0] rd1Index,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              wrAccept
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_ok;
  logic [DATA_W-1:0] q [DEPTH];

  assign clrBusy  = (state == ST_CLEAR);
  assign wrAccept = ~clrBusy;
  assign wr_ok    = wrEn & wrAccept;

  // Clear sequencer: walks every entry once, then returns to idle; requests while busy are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clrReq) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: begin
          if (clr_ptr == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // One storage entry per index; enable is the decoded write or the sequencer hit
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic wr_hit;
    logic clr_hit;

    assign wr_hit  = wr_ok && (wrIndex == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));
    assign clr_hit = clrBusy && (clr_ptr == ADDR_W'(i));

    reg_entry #(
      .DATA_W (DATA_W)
    ) u_entry (
      .clk (clk),
      .rst (rst),
      .en  (wr_hit | clr_hit),
      .clr (clr_hit),
      .d   (dataIn),
      .q   (q[i])
    );
  end

  // Read port 0: array read, then forward an accepted write, then force the zero register
  always_comb begin
    dataOut0 = q[rd0Index];
    if ((BYPASS != 0) && wr_ok && (wrIndex == rd0Index)) begin
      dataOut0 = dataIn;
    end
    if ((ZERO_REG != 0) && (rd0Index == '0)) begin
      dataOut0 = '0;
    end
  end

  // Read port 1: same selection as port 0, evaluated independently
  always_comb begin
    dataOut1 = q[rd1Index];
    if ((BYPASS != 0) && wr_ok && (wrIndex == rd1Index)) begin
      dataOut1 = dataIn;
    end
    if ((ZERO_REG != 0) && (rd1Index == '0)) begin
      dataOut1 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param in three configurations
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst, wrEn, clrReq;
  logic [3:0]  wrIndex, rd0Index, rd1Index;
  logic [31:0] dataIn;

  logic [31:0] d0_a, d1_a, d0_nb, d1_nb, d0_z, d1_z;
  logic        busy_a, acc_a, busy_nb, acc_nb, busy_z, acc_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_param #(.ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrIndex(wrIndex), .dataIn(dataIn),
    .rd0Index(rd0Index), .rd1Index(rd1Index), .dataOut0(d0_a), .dataOut1(d1_a),
    .clrReq(clrReq), .clrBusy(busy_a), .wrAccept(acc_a));

  reg_file_param #(.ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrIndex(wrIndex), .dataIn(dataIn),
    .rd0Index(rd0Index), .rd1Index(rd1Index), .dataOut0(d0_nb), .dataOut1(d1_nb),
    .clrReq(clrReq), .clrBusy(busy_nb), .wrAccept(acc_nb));

  reg_file_param #(.ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrIndex(wrIndex), .dataIn(dataIn),
    .rd0Index(rd0Index), .rd1Index(rd1Index), .dataOut0(d0_z), .dataOut1(d1_z),
    .clrReq(clrReq), .clrBusy(busy_z), .wrAccept(acc_z));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] mem  [16];
  logic [31:0] memz [16];
  logic        m_busy;
  int          m_ptr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return d0_a;
      1: return d1_a;
      2: return d0_nb;
      3: return d1_nb;
      4: return d0_z;
      5: return d1_z;
      6: return {31'd0, busy_a};
      7: return {31'd0, acc_a};
      8: return {31'd0, busy_nb};
      default: return {31'd0, busy_z};
    endcase
  endfunction

  // v: 0 bypass, 1 no bypass, 2 bypass with zero register
  function automatic logic [31:0] model_rd(input int v, input logic [3:0] idx);
    if (v == 2 && idx == 4'd0) return 32'd0;
    if (v != 1 && wrEn && !m_busy && wrIndex == idx) return dataIn;
    return (v == 2) ? memz[idx] : mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = '0;
      memz[i] = '0;
    end
    m_busy = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic push_all(input string tag);
    sb_t it;
    for (int s = 0; s < 10; s++) begin
      it.tag = $sformatf("%s_s%0d", tag, s);
      it.sel = s;
      case (s)
        0: it.exp = model_rd(0, rd0Index);
        1: it.exp = model_rd(0, rd1Index);
        2: it.exp = model_rd(1, rd0Index);
        3: it.exp = model_rd(1, rd1Index);
        4: it.exp = model_rd(2, rd0Index);
        5: it.exp = model_rd(2, rd1Index);
        7: it.exp = {31'd0, !m_busy};
        default: it.exp = {31'd0, m_busy};
      endcase
      sbq.push_back(it);
    end
  endtask

  task automatic drain();
    sb_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      check_val(it.tag, obs(it.sel), it.exp);
    end
  endtask

  task automatic look(input string tag);
    #1;
    push_all(tag);
    drain();
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (m_busy) begin
        mem[m_ptr]  = '0;
        memz[m_ptr] = '0;
        if (m_ptr == 15) m_busy = 1'b0;
        else m_ptr++;
      end else begin
        if (wrEn) begin
          mem[wrIndex] = dataIn;
          if (wrIndex != 4'd0) memz[wrIndex] = dataIn;
        end
        if (clrReq) begin
          m_busy = 1'b1;
          m_ptr  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wrEn = 1'b0; clrReq = 1'b0; wrIndex = '0; dataIn = '0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      wrEn = 1'b1; wrIndex = 4'(i); dataIn = $urandom | 32'h1;
      step();
    end
    wrEn = 1'b0;
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b0; idle_inputs(); rd0Index = '0; rd1Index = 4'd3;
    model_reset();

    // Reset pulse between clock edges
    #2 rst = 1'b1; model_reset();
    look("reset");
    check_val("reset_busy", {31'd0, busy_a}, 32'd0);
    check_val("reset_acc", {31'd0, acc_a}, 32'd1);
    #1 rst = 1'b0;
    step();

    // Write then read back
    wrEn = 1'b1; wrIndex = 4'd5; dataIn = 32'hDEADBEEF; rd0Index = 4'd5; rd1Index = 4'd6;
    look("wr5");
    check_val("wr5_nb_old", d0_nb, 32'd0);
    step();
    wrEn = 1'b0;
    look("rd5");
    check_val("rd5_val", d0_a, 32'hDEADBEEF);
    check_val("rd6_zero", d1_a, 32'd0);

    // Bypass against the no-bypass configuration
    wrEn = 1'b1; wrIndex = 4'd3; dataIn = 32'h11111111;
    step();
    dataIn = 32'h12345678; rd0Index = 4'd3; rd1Index = 4'd3;
    look("byp3");
    check_val("byp3_p0", d0_a, 32'h12345678);
    check_val("byp3_p1", d1_a, 32'h12345678);
    check_val("byp3_nb", d0_nb, 32'h11111111);
    step();

    // Zero register
    wrEn = 1'b1; wrIndex = 4'd0; dataIn = 32'hFFFFFFFF; rd0Index = 4'd0; rd1Index = 4'd0;
    look("zw");
    check_val("zero_wcyc", d0_z, 32'd0);
    step();
    wrEn = 1'b0;
    look("zr");
    check_val("zero_after", d0_z, 32'd0);
    check_val("nz_after", d0_a, 32'hFFFFFFFF);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      wrEn = 1'($urandom); wrIndex = 4'($urandom); dataIn = $urandom;
      rd0Index = 4'($urandom); rd1Index = (n % 3 == 0) ? wrIndex : 4'($urandom);
      look($sformatf("rnd%0d", n));
      step();
    end

    // Bulk clear with dropped write and ignored second request
    idle_inputs();
    fill_all();
    clrReq = 1'b1;
    look("clr_req");
    step();
    clrReq = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      wrEn = (c == 4); wrIndex = 4'd9; dataIn = 32'hCAFEF00D;
      clrReq = (c == 8);
      rd0Index = 4'($urandom); rd1Index = 4'd9;
      look($sformatf("clr%0d", c));
      if (c == 4) check_val("clr_drop_acc", {31'd0, acc_a}, 32'd0);
      if (busy_a) busy_cnt++;
      step();
    end
    idle_inputs();
    check_val("clr_len", busy_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      rd0Index = 4'(i); rd1Index = 4'(15 - i);
      look($sformatf("clr_rd%0d", i));
      check_val($sformatf("clr_zero%0d", i), d0_a, 32'd0);
    end

    // Reset in the middle of a clear
    fill_all();
    clrReq = 1'b1;
    step();
    clrReq = 1'b0;
    for (int c = 1; c < 7; c++) step();
    #2 rst = 1'b1; model_reset();
    #1;
    check_val("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd0Index = 4'(i); rd1Index = 4'(i);
      look($sformatf("mid_rst%0d", i));
      check_val($sformatf("mid_rst_zero%0d", i), d0_a, 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    wrEn = 1'b1; wrIndex = 4'd15; dataIn = 32'hA5A5A5A5;
    step();
    wrEn = 1'b0; rd0Index = 4'd15;
    look("post_rst");
    check_val("post_rst_rd15", d0_a, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
